alu_seq: RTL and testbench
==========================

# alu_seq

Command sequencer on the initiator side of the 4-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and drives the registered ALU inputs. After a configurable settle time it captures the ALU result and flags, then returns them through a small response FIFO. It sits between the top-level pin logic and the combinational ALU, so chained operations run without pin-level sequencing.

## Interface
- `SETTLE`, default 1: cycles ALU inputs are held before capture (1–15).
- `DEPTH`, default 4: response FIFO entries (power of 2, ≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_sel` in 3: ALU opcode, passed through unmodified.
- `cmd_chain` in 1: when 1, A is the last captured result and `cmd_a` is ignored.
- `alu_a` out 4: registered operand A to the ALU.
- `alu_b` out 4: registered operand B to the ALU.
- `alu_sel` out 3: registered opcode to the ALU.
- `alu_out` in 4: ALU result.
- `alu_carry` in 1: ALU carry flag.
- `alu_ovf` in 1: ALU overflow flag.
- `alu_zero` in 1: ALU zero flag.
- `alu_sign` in 1: ALU sign flag.
- `rsp_valid` out 1: FIFO non-empty.
- `rsp_ready` in 1: consumer pops the head entry.
- `rsp_data` out 8: {sign, zero, ovf, carry, result[3:0]}, same packing as the chip output pins.
- `busy` out 1: state is not IDLE.
- `op_count` out 8: number of completed captures; wraps 255→0.

## Operation
- States are IDLE, DRIVE and CAPTURE.
- IDLE:
  - `cmd_ready` = !fifo_full.
  - On handshake: register `alu_a` (= acc if `cmd_chain`, else `cmd_a`), `alu_b` and `alu_sel`.
  - Load settle counter with SETTLE-1 and go to DRIVE.
- DRIVE:
  - `cmd_ready`=0; `alu_*` held stable.
  - Decrement the counter; go to CAPTURE when it reads 0.
- CAPTURE, one cycle:
  - Sample `alu_out` and the flags.
  - Push the packed byte into the FIFO, set acc ← `alu_out`, `op_count`+1.
  - Go to IDLE.
- Only one command is in flight and it is accepted only when the FIFO is not full, so a push never overflows.
- FIFO is show-ahead: `rsp_data` is the head entry while `rsp_valid`, and reads 8'h00 when empty.
- Pop on `rsp_valid && rsp_ready`. `rsp_ready` while empty is ignored.
- Push and pop in the same cycle leave the count unchanged, and the data is ordered correctly.
- `alu_*` keep their last values in IDLE and do not return to zero.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `alu_a`/`alu_b`/`alu_sel`=0, acc=0, FIFO empty, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `op_count`=0.
- `cmd_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Handshake at edge E0:
  - `alu_*` valid after E0.
  - DRIVE lasts SETTLE cycles, then CAPTURE lasts one cycle.
  - FIFO written at edge E0+SETTLE+1; `rsp_valid` rises after that edge.
- Command-to-response latency is SETTLE+1 edges.
- Back-to-back rate is one command per SETTLE+2 cycles. `cmd_ready` re-rises the cycle after CAPTURE.
- Chained command: acc is updated at the CAPTURE edge, so the very next accepted command sees the new value.
- FIFO full: `cmd_ready` stays 0 until a pop. A pop in the same cycle does not raise `cmd_ready` combinationally; it rises the next cycle.
- Reset mid-operation: the in-flight command is dropped, the FIFO is flushed, and acc is cleared. No partial entry appears.

## Structure
- `alu_seq_pkg` holds:
  - the state enum;
  - `DATA_W`=4 and `SEL_W`=3;
  - flag bit positions `RSP_CARRY`=4, `RSP_OVF`=5, `RSP_ZERO`=6, `RSP_SIGN`=7.
- Sub-module `alu_seq_fifo`: synchronous show-ahead FIFO, parameter DEPTH, 8-bit data, with full/empty outputs and wrap-around pointers.
- The existing `ALU` is instantiated by the top level, not inside `alu_seq`.

## Test plan
For each scenario the bench stubs the ALU and drives its outputs.

- Basic, SETTLE=1: cmd a=3, b=5, sel=2.
  - `alu_a`=3, `alu_b`=5, `alu_sel`=2 after E0.
  - Bench returns out=8, sign=1, other flags 0.
  - `rsp_valid` after E2 with `rsp_data`=8'h88; `op_count`=1.
- Chain: first command returns out=4'h6; second command has `cmd_chain`=1 and `cmd_a`=F.
  - Second command drives `alu_a`=6.
  - Zero flag with out=0 packs as `rsp_data`=8'h40.
- FIFO full, DEPTH=4, `rsp_ready`=0: issue 5 commands.
  - `cmd_ready` stays low after the 4th capture.
  - One pop, then `cmd_ready` rises the next cycle.
  - The 5th response is ordered last.
- Simultaneous push/pop at count=2: count stays 2, and the head advances in order.
- SETTLE=3: the bench changes `alu_out` during DRIVE.
  - The value present in the CAPTURE cycle is the one stored.
  - Latency is 4 edges.
- Reset asserted in DRIVE with 2 FIFO entries:
  - Outputs go to reset values immediately (`rsp_valid`=0, `busy`=0, `alu_*`=0).
  - No response appears after release.
  - `op_count` wraps from 255 to 0 on the 256th capture.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// State encoding, datapath widths and response flag positions.
package alu_seq_pkg;
    localparam int DATA_W    = 4;
    localparam int SEL_W     = 3;
    localparam int RSP_CARRY = 4;
    localparam int RSP_OVF   = 5;
    localparam int RSP_ZERO  = 6;
    localparam int RSP_SIGN  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_seq_fifo.sv
// Show-ahead response FIFO, 8-bit entries.
// Head is visible on rdata while non-empty, zero otherwise.
module alu_seq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset; empty masks stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_seq.sv
// Initiator-side sequencer for the 4-bit ALU.
// Drives registered operands, captures result, queues responses.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic [7:0]        op_count
);
    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [7:0]        pkt;
    logic              full;
    logic              empty;
    logic              push;

    assign cmd_ready = !rst && (state == IDLE) && !full;
    assign push      = (state == CAPTURE);
    assign busy      = (state != IDLE);
    assign rsp_valid = !empty;

    // Pack result and flags in chip pin order.
    always_comb begin
        pkt              = '0;
        pkt[DATA_W-1:0]  = alu_out;
        pkt[RSP_CARRY]   = alu_carry;
        pkt[RSP_OVF]     = alu_ovf;
        pkt[RSP_ZERO]    = alu_zero;
        pkt[RSP_SIGN]    = alu_sign;
    end

    // Sequencer: accept, hold for settle time, capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            op_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a   <= cmd_chain ? acc : cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_sel;
                        cnt     <= 4'(SETTLE - 1);
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) state <= CAPTURE;
                    else           cnt   <= cnt - 1'b1;
                end
                CAPTURE: begin
                    acc      <= alu_out;
                    op_count <= op_count + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rsp_ready),
        .wdata (pkt),
        .rdata (rsp_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a stubbed ALU.
// Queue-based response model, two SETTLE configurations.
module tb_alu_seq;
    logic       clk = 0;
    logic       rst;

    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out;
    logic [2:0] cmd_sel, alu_sel;
    logic       alu_carry, alu_ovf, alu_zero, alu_sign;
    logic       rsp_valid, rsp_ready, busy;
    logic [7:0] rsp_data, op_count;

    logic       s3_cmd_valid, s3_cmd_ready, s3_cmd_chain;
    logic [3:0] s3_cmd_a, s3_cmd_b, s3_alu_a, s3_alu_b, s3_alu_out;
    logic [2:0] s3_cmd_sel, s3_alu_sel;
    logic       s3_carry, s3_ovf, s3_zero, s3_sign;
    logic       s3_rsp_valid, s3_rsp_ready, s3_busy;
    logic [7:0] s3_rsp_data, s3_op_count;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] q[$];
    logic [3:0] acc   = 0;
    logic [7:0] opcnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.SETTLE(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy),
        .op_count(op_count)
    );

    alu_seq #(.SETTLE(3), .DEPTH(4)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
        .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_sel(s3_cmd_sel),
        .cmd_chain(s3_cmd_chain),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_sel(s3_alu_sel),
        .alu_out(s3_alu_out), .alu_carry(s3_carry),
        .alu_ovf(s3_ovf), .alu_zero(s3_zero),
        .alu_sign(s3_sign),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_data(s3_rsp_data), .busy(s3_busy),
        .op_count(s3_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50 && cmd_ready !== 1'b1; i++)
            @(negedge clk);
        if (i == 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_one();
        chk("pop_valid", rsp_valid, 1);
        chk("pop_data", rsp_data, q[0]);
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        void'(q.pop_front());
    endtask

    task automatic drain();
        while (q.size() > 0) pop_one();
        chk("empty_valid", rsp_valid, 0);
        chk("empty_data", rsp_data, 8'h00);
    endtask

    // fl = {sign, zero, ovf, carry}
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic ch,
                         input logic [3:0] out, input logic [3:0] fl,
                         input bit pop_cap);
        logic [3:0] ea;
        wait_ready();
        ea        = ch ? acc : a;
        cmd_valid = 1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_chain = ch;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, sel);
        chk("busy_drive", busy, 1);
        chk("ready_drive", cmd_ready, 0);
        alu_out = out;
        {alu_sign, alu_zero, alu_ovf, alu_carry} = fl;
        @(posedge clk);
        @(negedge clk);
        chk("valid_pre", rsp_valid, q.size() != 0);
        if (pop_cap) begin
            chk("cap_head", rsp_data, q[0]);
            rsp_ready = 1;
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        if (pop_cap) void'(q.pop_front());
        q.push_back({fl, out});
        acc   = out;
        opcnt = opcnt + 8'd1;
        chk("op_count", op_count, opcnt);
        chk("valid_post", rsp_valid, 1);
        chk("rsp_head", rsp_data, q[0]);
        chk("busy_idle", busy, 0);
        chk("ready_after", cmd_ready, q.size() < 4);
    endtask

    initial begin
        rst = 1;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; cmd_chain = 0;
        alu_out = 0; {alu_sign, alu_zero, alu_ovf, alu_carry} = 0;
        rsp_ready = 0;
        s3_cmd_valid = 0; s3_cmd_a = 0; s3_cmd_b = 0; s3_cmd_sel = 0;
        s3_cmd_chain = 0; s3_alu_out = 0;
        {s3_sign, s3_zero, s3_ovf, s3_carry} = 0;
        s3_rsp_ready = 0;

        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 8'h00);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_opcnt", op_count, 0);
        rst = 0;
        #1;
        chk("ready_release", cmd_ready, 1);
        chk("s3_ready_release", s3_cmd_ready, 1);
        @(negedge clk);

        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        chk("pop_empty_ignored", rsp_valid, 0);

        issue(4'd3, 4'd5, 3'd2, 0, 4'd8, 4'b1000, 0);
        chk("basic_pack", rsp_data, 8'h88);
        chk("basic_opcnt", op_count, 1);
        chk("basic_alu_hold", {alu_a, alu_b, alu_sel}, {4'd3, 4'd5, 3'd2});
        drain();

        issue(4'd1, 4'd5, 3'd0, 0, 4'h6, 4'b0000, 0);
        pop_one();
        issue(4'hF, 4'd0, 3'd3, 1, 4'h0, 4'b0100, 0);
        chk("chain_a", alu_a, 4'd6);
        chk("chain_pack", rsp_data, 8'h40);
        drain();

        for (int i = 0; i < 4; i++)
            issue(4'($urandom), 4'($urandom), 3'($urandom), 0,
                  4'($urandom), 4'($urandom), 0);
        chk("full_ready", cmd_ready, 0);
        cmd_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold", cmd_ready, 0);
            chk("full_busy", busy, 0);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        #1;
        chk("pop_no_comb_ready", cmd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        void'(q.pop_front());
        chk("ready_after_pop", cmd_ready, 1);
        issue(4'hA, 4'h5, 3'd7, 0, 4'hC, 4'b1010, 0);
        chk("fifth_last", q.size(), 4);
        drain();

        issue(4'd1, 4'd1, 3'd1, 0, 4'd2, 4'b0000, 0);
        issue(4'd2, 4'd2, 3'd2, 0, 4'd4, 4'b0001, 0);
        issue(4'd3, 4'd3, 3'd3, 0, 4'd6, 4'b0010, 1);
        chk("pushpop_count", q.size(), 2);
        chk("pushpop_head", rsp_data, 8'h14);
        drain();

        wait (s3_cmd_ready === 1'b1);
        @(negedge clk);
        s3_cmd_valid = 1;
        s3_cmd_a = 4'd2; s3_cmd_b = 4'd7; s3_cmd_sel = 3'd1;
        @(posedge clk);
        @(negedge clk);
        s3_cmd_valid = 0;
        s3_alu_out = 4'd1;
        chk("s3_alu_a", s3_alu_a, 4'd2);
        @(posedge clk);
        @(negedge clk);
        s3_alu_out = 4'd5;
        chk("s3_valid_e1", s3_rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        s3_alu_out = 4'hC;
        chk("s3_busy", s3_busy, 1);
        chk("s3_valid_e2", s3_rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        s3_alu_out = 4'd9;
        s3_carry = 1;
        chk("s3_valid_e3", s3_rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        s3_carry = 0;
        chk("s3_valid_e4", s3_rsp_valid, 1);
        chk("s3_data", s3_rsp_data, 8'h19);
        chk("s3_opcnt", s3_op_count, 1);
        chk("s3_ready_after", s3_cmd_ready, 1);
        s3_rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        s3_rsp_ready = 0;
        chk("s3_empty", s3_rsp_valid, 0);

        while (opcnt != 8'd255) begin
            if (q.size() == 4) pop_one();
            issue(4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  q.size() > 0 && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) pop_one();
        end
        chk("opcnt_255", op_count, 8'd255);
        if (q.size() == 4) pop_one();
        issue(4'd7, 4'd1, 3'd0, 0, 4'd3, 4'b0000, 0);
        chk("opcnt_wrap", op_count, 8'd0);
        drain();

        issue(4'd1, 4'd2, 3'd4, 0, 4'd5, 4'b0000, 0);
        issue(4'd6, 4'd7, 3'd5, 0, 4'd9, 4'b1000, 0);
        wait_ready();
        cmd_valid = 1;
        cmd_a = 4'hE; cmd_b = 4'hD; cmd_sel = 3'd6; cmd_chain = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("mid_rst_data", rsp_data, 8'h00);
        chk("mid_rst_opcnt", op_count, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 0;
        q.delete();
        acc = 0;
        opcnt = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_after_rst", rsp_valid, 0);
        end
        issue(4'hF, 4'd1, 3'd2, 1, 4'd1, 4'b0000, 0);
        chk("acc_cleared", alu_a, 4'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
